padd_tap_sink: RTL and testbench
================================

# padd_tap_sink

Receiving end of the 18-bit pre-adder shift chain. Samples the chain input (`si`, driven by an upstream `Gowin_PADD` `so`) on each `ce` into an NTAPS-deep delay line and forwards the oldest sample on its own `so`. Each time the window is full, it snapshots the window and emits the symmetric pair sums one per handshake over a valid/ready stream. It sits between the PADD chain and the symmetric-FIR coefficient multiply stage.

## Interface
- `WIDTH`, 18: sample and sum width.
- `NTAPS`, 8: delay-line depth; even, ≥2.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; wins over every other input.
- `ce`  in  1  sample enable; shifts `si` into the delay line.
- `si`  in  WIDTH  chain input sample.
- `so`  out  WIDTH  chain continuation; registered `tap[NTAPS-1]`.
- `dout`  out  WIDTH  pair sum `shadow[k] + shadow[NTAPS-1-k]`.
- `pair_idx`  out  $clog2(NTAPS/2) (min 1)  index k of `dout`.
- `dout_valid`  out  1  `dout`/`pair_idx` valid.
- `dout_ready`  in  1  consumer accepts when high with `dout_valid`.
- `busy`  out  1  high in EMIT.
- `overrun`  out  1  one-cycle pulse when a full window is dropped.

## Operation
- Delay line: `tap[0]` newest. On `ce`: `tap[0]<=si`, `tap[k]<=tap[k-1]`. It never stalls, regardless of output backpressure.
- `so` equals `tap[NTAPS-1]` (post-shift value).
- Fill counter increments on each `ce` and saturates at NTAPS. A window is "complete" on any `ce` edge where the post-shift fill equals NTAPS. After the first fill, every `ce` completes a new sliding window.
- FSM states:
  - IDLE: on a completed window, load `shadow` with the post-shift taps (`si`, `tap[0..NTAPS-2]`), load `dout` with pair 0, set `pair_idx=0` and `dout_valid=1`, then go to EMIT.
  - EMIT: hold `dout`/`pair_idx` while `dout_ready=0`. On handshake with k<NTAPS/2-1, load pair k+1. On handshake of the last pair:
    - if a window completes in the same cycle, snapshot it and go to EMIT with pair 0 (no bubble);
    - otherwise set `dout_valid<=0` and go to IDLE.
- Overrun: a window that completes in EMIT without last-pair handshake in that cycle is dropped. `overrun` pulses for 1 cycle and the taps still shift.
- Arithmetic: unsigned WIDTH-bit add with carry discarded (mod 2^WIDTH), matching PADD output width.
- Reset: all taps, `shadow`, fill, `so`, `dout`, `pair_idx` go to 0. `dout_valid`, `busy` and `overrun` go to 0. State goes to IDLE. A reset mid-EMIT aborts the window; the remaining pairs are never emitted.

## Timing
- Latency: `ce` completing a window at edge E makes `dout_valid`=1 with pair 0 in the cycle after E.
- Throughput: 1 pair/cycle with `dout_ready` held high. A window drains in NTAPS/2 cycles.
- `so` updates at the same edge as the tap shift: one-cycle register from `si` for NTAPS=1-equivalent chain timing, NTAPS cycles of `ce` overall.
- `overrun` is asserted in the cycle after the dropping edge, for exactly one cycle.
- `busy` equals `dout_valid` and is registered.
- After `reset` is released, the first window needs NTAPS `ce` samples. `ce` during `reset` is ignored.

## Test plan
- Reset/fill:
  - Stimulus: `reset` 1 cycle, then `ce` with `si`=1..8 on consecutive cycles, `dout_ready`=1.
  - Required response: all outputs 0 after reset. After the 8th sample, `so`=1, and `dout`=9 with `pair_idx`=0,1,2,3 on 4 consecutive cycles. `dout_valid` drops afterwards.
- Backpressure:
  - Stimulus: same fill, `dout_ready`=0 for 3 cycles.
  - Required response: `dout`=9, `pair_idx`=0 held stable with `dout_valid`=1. Draining resumes when ready rises.
- Overrun/sliding:
  - Stimulus: during EMIT with ready low, `ce` with `si`=9 occurs; drain; then `ce` with `si`=10.
  - Required response: `overrun` is a single-cycle pulse, and `so`=2 after the `si`=9 shift. The next window (10,9,…,3) emits 13 for all 4 pairs.
- Wrap:
  - Stimulus: samples 1 then seven × 18'h3FFFF.
  - Required response: pair 0 `dout`=0 (carry dropped). Pairs 1–3 `dout`=18'h3FFFE.
- Back-to-back:
  - Stimulus: full window, ready=1, `ce` in the cycle of the last-pair handshake.
  - Required response: `dout_valid` stays 1 with no gap, `pair_idx` returns to 0, `overrun`=0.
- Reset mid-EMIT:
  - Stimulus: assert `reset` after pair 1 is accepted.
  - Required response: `dout_valid`=0 in the next cycle, with no further pairs. 8 new samples are needed before the next `dout_valid`.

Source files
------------

// File: rtl/padd_tap_sink_if.sv
// Valid/ready stream carrying symmetric pair sums and their pair index.
interface padd_tap_sink_if #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned NTAPS = 8
);
    localparam int unsigned IDXW = (NTAPS / 2 > 1) ? $clog2(NTAPS / 2) : 1;

    logic [WIDTH-1:0] dout;
    logic [IDXW-1:0]  pair_idx;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, output pair_idx, output dout_valid, input dout_ready);
    modport slave  (input dout, input pair_idx, input dout_valid, output dout_ready);
endinterface

// File: rtl/padd_tap_sink.sv
// Tail of the pre-adder shift chain: NTAPS-deep delay line that snapshots each full
// window and streams the symmetric pair sums shadow[k] + shadow[NTAPS-1-k].
module padd_tap_sink #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned NTAPS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [WIDTH-1:0]     si,
    output logic [WIDTH-1:0]     so,
    padd_tap_sink_if.master      stream,
    output logic                 busy,
    output logic                 overrun
);
    localparam int unsigned NPAIR = NTAPS / 2;
    localparam int unsigned IDXW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int unsigned FW    = $clog2(NTAPS + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]       state;
    logic [FW-1:0]    fill;
    logic [WIDTH-1:0] tap    [NTAPS];
    logic [WIDTH-1:0] shadow [NTAPS];

    logic [WIDTH-1:0] shifted [NTAPS];
    logic [FW-1:0]    fill_inc;
    logic             win;
    logic             hs;
    logic             last;
    logic [WIDTH-1:0] snap_sum;
    logic [WIDTH-1:0] next_sum;
    int               nidx;

    always_comb begin
        shifted[0] = si;
        for (int k = 1; k < int'(NTAPS); k++) begin
            shifted[k] = tap[k-1];
        end
    end

    always_comb begin
        fill_inc = (fill == FW'(NTAPS)) ? fill : fill + FW'(1);
        win      = ce && (fill_inc == FW'(NTAPS));
        hs       = stream.dout_valid && stream.dout_ready;
        last     = (stream.pair_idx == IDXW'(NPAIR - 1));
        // Pair 0 comes straight from the post-shift taps, so no bubble after a snapshot.
        snap_sum = shifted[0] + shifted[NTAPS-1];
        nidx     = int'(stream.pair_idx) + 1;
        if (nidx > int'(NPAIR) - 1) begin
            nidx = int'(NPAIR) - 1;
        end
        next_sum = shadow[nidx] + shadow[int'(NTAPS) - 1 - nidx];
    end

    assign so = tap[NTAPS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            fill              <= '0;
            stream.dout       <= '0;
            stream.pair_idx   <= '0;
            stream.dout_valid <= 1'b0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            for (int k = 0; k < int'(NTAPS); k++) begin
                tap[k]    <= '0;
                shadow[k] <= '0;
            end
        end else begin
            overrun <= 1'b0;
            if (ce) begin
                tap  <= shifted;
                fill <= fill_inc;
            end
            case (state)
                S_IDLE: begin
                    if (win) begin
                        shadow            <= shifted;
                        stream.dout       <= snap_sum;
                        stream.pair_idx   <= '0;
                        stream.dout_valid <= 1'b1;
                        busy              <= 1'b1;
                        state             <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (hs && !last) begin
                        stream.dout     <= next_sum;
                        stream.pair_idx <= stream.pair_idx + IDXW'(1);
                    end else if (hs && last) begin
                        if (win) begin
                            shadow          <= shifted;
                            stream.dout     <= snap_sum;
                            stream.pair_idx <= '0;
                        end else begin
                            stream.dout_valid <= 1'b0;
                            busy              <= 1'b0;
                            state             <= S_IDLE;
                        end
                    end
                    // Window completed while the previous one is still draining: drop it.
                    if (win && !(hs && last)) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_padd_tap_sink.sv
// Directed bench for padd_tap_sink: fill, backpressure, overrun, wrap, back-to-back, reset.
module tb_padd_tap_sink;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [17:0] si;
    logic [17:0] so;
    logic        busy;
    logic        overrun;
    int          vectors = 0;
    int          miscompares = 0;

    padd_tap_sink_if #(.WIDTH(18), .NTAPS(8)) s_if ();

    padd_tap_sink #(.WIDTH(18), .NTAPS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .si      (si),
        .so      (so),
        .stream  (s_if),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_pair(input string tag, input int k, input logic [17:0] v);
        chk({tag, " valid"}, 32'(s_if.dout_valid), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " idx"}, 32'(s_if.pair_idx), 32'(k));
        chk({tag, " dout"}, 32'(s_if.dout), 32'(v));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [17:0] v);
        ce = 1'b1;
        si = v;
        tick();
        ce = 1'b0;
    endtask

    task automatic fill_1_to_8();
        for (int i = 1; i <= 7; i++) push(18'(i));
        chk("pre-window valid", 32'(s_if.dout_valid), 32'd0);
        push(18'd8);
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b0;
        si = '0;
        s_if.dout_ready = 1'b1;
        tick();
        tick();
        chk("rst so", 32'(so), 32'd0);
        chk("rst dout", 32'(s_if.dout), 32'd0);
        chk("rst idx", 32'(s_if.pair_idx), 32'd0);
        chk("rst valid", 32'(s_if.dout_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        reset = 1'b0;

        // Reset/fill with ready high
        fill_1_to_8();
        chk("fill so", 32'(so), 32'd1);
        chk_pair("fill p0", 0, 18'd9);
        tick(); chk_pair("fill p1", 1, 18'd9);
        tick(); chk_pair("fill p2", 2, 18'd9);
        tick(); chk_pair("fill p3", 3, 18'd9);
        tick();
        chk("fill done valid", 32'(s_if.dout_valid), 32'd0);
        chk("fill done busy", 32'(busy), 32'd0);

        // Backpressure
        do_reset();
        s_if.dout_ready = 1'b0;
        fill_1_to_8();
        chk_pair("bp hold0", 0, 18'd9);
        tick(); chk_pair("bp hold1", 0, 18'd9);
        tick(); chk_pair("bp hold2", 0, 18'd9);
        s_if.dout_ready = 1'b1;
        tick(); chk_pair("bp p1", 1, 18'd9);
        tick(); chk_pair("bp p2", 2, 18'd9);
        tick(); chk_pair("bp p3", 3, 18'd9);
        tick(); chk("bp done valid", 32'(s_if.dout_valid), 32'd0);

        // Overrun then sliding window
        do_reset();
        s_if.dout_ready = 1'b0;
        fill_1_to_8();
        chk("ovr pre", 32'(overrun), 32'd0);
        push(18'd9);
        chk("ovr pulse", 32'(overrun), 32'd1);
        chk("ovr so", 32'(so), 32'd2);
        chk_pair("ovr held", 0, 18'd9);
        tick();
        chk("ovr cleared", 32'(overrun), 32'd0);
        s_if.dout_ready = 1'b1;
        tick(); chk_pair("ovr p1", 1, 18'd9);
        tick(); chk_pair("ovr p2", 2, 18'd9);
        tick(); chk_pair("ovr p3", 3, 18'd9);
        tick(); chk("ovr drained", 32'(s_if.dout_valid), 32'd0);
        push(18'd10);
        chk_pair("slide p0", 0, 18'd13);
        chk("slide overrun", 32'(overrun), 32'd0);
        tick(); chk_pair("slide p1", 1, 18'd13);
        tick(); chk_pair("slide p2", 2, 18'd13);
        tick(); chk_pair("slide p3", 3, 18'd13);
        tick();

        // Wrap: carry discarded
        do_reset();
        push(18'd1);
        for (int i = 0; i < 7; i++) push(18'h3FFFF);
        chk_pair("wrap p0", 0, 18'd0);
        tick(); chk_pair("wrap p1", 1, 18'h3FFFE);
        tick(); chk_pair("wrap p2", 2, 18'h3FFFE);
        tick(); chk_pair("wrap p3", 3, 18'h3FFFE);
        tick(); chk("wrap done", 32'(s_if.dout_valid), 32'd0);

        // Back-to-back: new window on last-pair handshake
        do_reset();
        fill_1_to_8();
        tick(); tick(); tick();
        chk_pair("b2b p3", 3, 18'd9);
        push(18'd20);
        chk_pair("b2b new p0", 0, 18'd22);
        chk("b2b overrun", 32'(overrun), 32'd0);
        tick(); chk_pair("b2b new p1", 1, 18'd11);
        tick(); tick(); tick();
        chk("b2b done", 32'(s_if.dout_valid), 32'd0);

        // Reset mid-EMIT, with ce during reset ignored
        do_reset();
        fill_1_to_8();
        tick(); tick();
        chk_pair("mid p2", 2, 18'd9);
        reset = 1'b1;
        ce = 1'b1;
        si = 18'd5;
        tick();
        reset = 1'b0;
        ce = 1'b0;
        chk("mid rst valid", 32'(s_if.dout_valid), 32'd0);
        chk("mid rst idx", 32'(s_if.pair_idx), 32'd0);
        chk("mid rst so", 32'(so), 32'd0);
        tick();
        chk("mid no more", 32'(s_if.dout_valid), 32'd0);
        fill_1_to_8();
        chk_pair("mid refill p0", 0, 18'd9);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
